// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised line, start-edge detect, mid-bit sampling,
// one-cycle valid / frame-error strobes.
module uart_rx #(
  parameter int CLK_FREQ  = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX_IN,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_ERR,
  output logic       RX_BUSY
);
  localparam int BAUD_CNT = CLK_FREQ * 1000000 / BAUD_RATE;
  localparam int HALF_CNT = BAUD_CNT / 2;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state, state_nxt;
  logic        sync1, rx_s, rx_s_d, fall;
  logic [15:0] baud_cnt, baud_nxt;
  logic [2:0]  bit_cnt, bit_nxt;
  logic [7:0]  shift, shift_nxt, data_nxt;
  logic        valid_nxt, err_nxt;

  // Synchroniser and edge flop reset high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= RX_IN;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign fall = rx_s_d & ~rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      RX_ERR   <= 1'b0;
      RX_BUSY  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      RX_DATA  <= data_nxt;
      RX_VALID <= valid_nxt;
      RX_ERR   <= err_nxt;
      RX_BUSY  <= (state_nxt != S_IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt + 16'd1;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = RX_DATA;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        baud_nxt = '0;
        if (fall) state_nxt = S_START;
      end
      S_START: begin
        // Half a bit in: confirm the start bit, after which sampling sits mid-bit.
        if (baud_cnt == HALF_LAST) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          shift_nxt = {rx_s, shift[7:1]};
          bit_nxt   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is still seen.
        if (baud_cnt == BAUD_LAST) begin
          baud_nxt  = '0;
          state_nxt = S_IDLE;
          if (rx_s) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames, random frames
// against a frame-level model, plus glitch and mid-frame reset sequences.
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_err, rx_busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nvalid = 0, nerr = 0, nbusy = 0, nboth = 0, vcyc = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLK_FREQ(50), .BAUD_RATE(5000000)) dut (
    .clk(clk), .rst_n(rst_n), .RX_IN(rx_in),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .RX_ERR(rx_err), .RX_BUSY(rx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      nvalid <= nvalid + 1;
      vcyc   <= cyc;
    end
    if (rx_err) nerr <= nerr + 1;
    if (rx_busy) nbusy <= nbusy + 1;
    if (rx_valid && rx_err) nboth <= nboth + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    rx_in = b;
    repeat (9) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int s);
    @(posedge clk); #1;
    rx_in = 1'b0;
    s = cyc;
    repeat (9) @(posedge clk);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  // Sends one frame and checks strobe counts, held data and latency.
  task automatic run_frame(input string nm, input logic [7:0] d, input logic stop,
                           input int gap, input int ev, input int ee, input logic [7:0] ed,
                           output int vc);
    int v0, e0, s;
    v0 = nvalid;
    e0 = nerr;
    send_frame(d, stop, s);
    @(negedge clk);
    check({nm, " valid count"}, nvalid - v0, ev);
    check({nm, " err count"}, nerr - e0, ee);
    check({nm, " data"}, int'(rx_data), int'(ed));
    check({nm, " busy after"}, int'(rx_busy), 0);
    vc = -1;
    if (ev == 1) begin
      check_rng({nm, " latency"}, vcyc - s, 95, 99);
      vc = vcyc;
    end
    for (int g = 0; g < gap; g++) send_bit(1'b1);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         gap;
    int         ev;
    int         ee;
    logic [7:0] ed;
  } vec_t;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[7];
    int   vc, prev_vc, prev_gap, v0, e0, b0, nv0, ne0;
    logic [7:0] d;
    logic stop;
    int   gap;

    tbl[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
    tbl[1] = '{8'h00, 1'b1, 2, 1, 0, 8'h00};
    tbl[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
    tbl[3] = '{8'h3C, 1'b1, 0, 1, 0, 8'h3C};
    tbl[4] = '{8'hC3, 1'b1, 2, 1, 0, 8'hC3};
    tbl[5] = '{8'h55, 1'b0, 2, 0, 1, 8'hC3};
    tbl[6] = '{8'h12, 1'b1, 2, 1, 0, 8'h12};

    // Reset and idle line
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset data", int'(rx_data), 0);
    check("reset busy", int'(rx_busy), 0);
    #1 rst_n = 1'b1;
    v0 = nvalid; e0 = nerr; b0 = nbusy;
    repeat (200) @(posedge clk);
    @(negedge clk);
    check("idle valid", nvalid - v0, 0);
    check("idle err", nerr - e0, 0);
    check("idle busy", nbusy - b0, 0);
    check("idle data", int'(rx_data), 0);

    // Directed table
    prev_vc = -1; prev_gap = 1;
    foreach (tbl[i]) begin
      run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].stop, tbl[i].gap,
                tbl[i].ev, tbl[i].ee, tbl[i].ed, vc);
      if (prev_gap == 0 && prev_vc >= 0 && vc >= 0)
        check($sformatf("vec%0d back-to-back spacing", i), vc - prev_vc, 100);
      prev_vc = vc; prev_gap = tbl[i].gap;
    end
    last_good = 8'h12;

    // Random frames against the frame-level model
    for (int i = 0; i < 30; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      if (stop) last_good = d;
      run_frame($sformatf("rnd%0d", i), d, stop, gap, stop ? 1 : 0, stop ? 0 : 1, last_good, vc);
    end

    // Short low glitch
    v0 = nvalid; e0 = nerr; b0 = nbusy;
    @(posedge clk); #1 rx_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_in = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("glitch busy cleared", int'(rx_busy), 0);
    check("glitch busy seen", int'(nbusy > b0), 1);
    repeat (100) @(posedge clk);
    check("glitch valid", nvalid - v0, 0);
    check("glitch err", nerr - e0, 0);

    // Reset during data bit 4 of 8'hF3 (bits 4..7 high so no false start after release)
    nv0 = nvalid; ne0 = nerr;
    d = 8'hF3;
    @(posedge clk); #1 rx_in = 1'b0;
    repeat (9) @(posedge clk);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    @(posedge clk); #1 rx_in = d[4];
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst data", int'(rx_data), 0);
    check("midrst busy", int'(rx_busy), 0);
    check("midrst valid", int'(rx_valid), 0);
    check("midrst err", int'(rx_err), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    for (int i = 5; i < 8; i++) send_bit(d[i]);
    send_bit(1'b1);
    repeat (3) send_bit(1'b1);
    @(negedge clk);
    check("midrst no valid", nvalid - nv0, 0);
    check("midrst no err", nerr - ne0, 0);
    run_frame("after reset", 8'h81, 1'b1, 2, 1, 0, 8'h81, vc);

    check("valid and err together", nboth, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
